shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 8 bits.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request; sampled only on a rising CLK edge.
REQ-005 OPERAND  input  8  value to shift, captured with START.
REQ-006 AMOUNT  input  8  requested shift count, captured with START.
REQ-007 SHIFTTYPE  input  2  operation select, captured with START: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 RESULT  output  8  registered working value / final result.
REQ-009 BUSY  output  1  high while in the SHIFT state.
REQ-010 DONE  output  1  one-cycle pulse; high while in the DONE state.
REQ-011 CARRYOUT  output  1  last bit shifted out; present only when SHIFT_CARRY_EN is defined.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 START SHALL be accepted only in IDLE or DONE, at edge E0.
- E0 loads RESULT<=OPERAND.
- E0 latches SHIFTTYPE.
- E0 loads the count with the effective amount N.
- E0 moves the block to SHIFT.
REQ-014 The effective amount N SHALL be:
- min(AMOUNT,8) for SLL, SRL and SRA.
- AMOUNT[2:0] for ROR.
REQ-015 At each edge in SHIFT with count!=0, the block SHALL shift RESULT by one position and decrement the count.
- SLL: bit0<=0.
- SRL: bit7<=0.
- SRA: bit7 keeps the sign.
- ROR: bit7<=old bit0.
REQ-016 At the edge in SHIFT with count==0, the block SHALL move to DONE.
- For N shifts, DONE SHALL be high in the cycle after edge E(N+1).
- N=0 gives DONE after E1, with RESULT=OPERAND.
REQ-017 From DONE, the next edge SHALL go to IDLE, unless START is high, in which case a new operation is accepted as a back-to-back load.
REQ-018 START during SHIFT SHALL be ignored, with no effect on RESULT, count or state.
REQ-019 RESULT SHALL hold its final value from DONE until the next accepted START.
REQ-020 BUSY SHALL be high only in SHIFT.
REQ-021 DONE SHALL be high only in DONE and SHALL never be high in the same cycle as BUSY.
REQ-022 Operand and type changes during SHIFT SHALL not affect the operation in progress.

Reset
REQ-023 RESET high at a clock edge SHALL force:
- state IDLE, count 0;
- RESULT 0x00, BUSY 0, DONE 0, CARRYOUT 0.
REQ-024 RESET SHALL take priority over START.
REQ-025 RESET asserted mid-operation SHALL abort it with no DONE pulse.

Configuration
REQ-026 With macro SHIFT_CARRY_EN defined:
- CARRYOUT SHALL exist and SHALL be cleared on every accepted START.
- On each shift step, CARRYOUT SHALL take the outgoing bit: old bit7 for SLL, old bit0 for SRL, SRA and ROR.
- CARRYOUT SHALL hold its value after DONE; N=0 leaves it 0.
REQ-027 Without SHIFT_CARRY_EN, the CARRYOUT port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 SLL, OPERAND=0x81, AMOUNT=1 -> RESULT=0x02, DONE after E2, CARRYOUT=1 (macro on).
REQ-029 SRA, OPERAND=0x80, AMOUNT=3 -> RESULT=0xF0, DONE after E4, BUSY high for 4 cycles.
REQ-030 ROR, OPERAND=0x01, AMOUNT=9 -> N=1, RESULT=0x80, DONE after E2; AMOUNT=8 -> RESULT=0x01, DONE after E1.
REQ-031 SRL, OPERAND=0xFF, AMOUNT=200 -> N=8, RESULT=0x00, DONE after E9, CARRYOUT=1.
REQ-032 SLL 0x01 by 5, START pulsed with OPERAND=0xAA at E2 -> ignored, RESULT=0x20; then START held high in the DONE cycle -> new operation loads back-to-back.
REQ-033 RESET at E2 of SRL 0xF0 by 4 -> next cycle IDLE, RESULT=0x00, no DONE pulse.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle 8-bit shifter that steps one bit per clock (SLL/SRL/SRA/ROR).
// Optional carry-out register is enabled by defining SHIFT_CARRY_EN.
module shift_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] operand,
  input  logic [7:0] amount,
  input  logic [1:0] shifttype,
  output logic [7:0] result,
  output logic       busy,
`ifdef SHIFT_CARRY_EN
  output logic       carryout,
`endif
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  state_e     state_q;
  logic [3:0] count_q;
  logic [1:0] type_q;
  logic [3:0] eff_n;
  logic [7:0] shifted;

  // Rotates wrap every 8 positions; linear shifts saturate at a full clear.
  always_comb begin
    eff_n = 4'd0;
    if (shifttype == OpRor) begin
      eff_n = {1'b0, amount[2:0]};
    end else if (amount > 8'd8) begin
      eff_n = 4'd8;
    end else begin
      eff_n = amount[3:0];
    end
  end

  always_comb begin
    shifted = result;
    unique case (type_q)
      OpSll:   shifted = {result[6:0], 1'b0};
      OpSrl:   shifted = {1'b0, result[7:1]};
      OpSra:   shifted = {result[7], result[7:1]};
      OpRor:   shifted = {result[0], result[7:1]};
      default: shifted = result;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic carry_bit;
  assign carry_bit = (type_q == OpSll) ? result[7] : result[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      type_q  <= OpSll;
      result  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carryout <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StShift;
            count_q <= eff_n;
            type_q  <= shifttype;
            result  <= operand;
            busy    <= 1'b1;
            done    <= 1'b0;
`ifdef SHIFT_CARRY_EN
            carryout <= 1'b0;
`endif
          end else begin
            state_q <= StIdle;
            done    <= 1'b0;
          end
        end
        StShift: begin
          if (count_q != 4'd0) begin
            result  <= shifted;
            count_q <= count_q - 4'd1;
`ifdef SHIFT_CARRY_EN
            carryout <= carry_bit;
`endif
          end else begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; carry checks follow SHIFT_CARRY_EN.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] operand;
  logic [7:0] amount;
  logic [1:0] shifttype;
  logic [7:0] result;
  logic       busy;
  logic       done;
`ifdef SHIFT_CARRY_EN
  logic       carryout;
`endif

  int total = 0;
  int bad = 0;
  int edges;
  int busy_cnt;
  int overlap;

  shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand   (operand),
    .amount    (amount),
    .shifttype (shifttype),
    .result    (result),
    .busy      (busy),
`ifdef SHIFT_CARRY_EN
    .carryout  (carryout),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issues one START at E0 and counts edges after E0 until DONE (bounded).
  task automatic run_op(input logic [1:0] t, input logic [7:0] op, input logic [7:0] amt);
    shifttype = t;
    operand   = op;
    amount    = amt;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    operand   = ~op;
    shifttype = ~t;
    edges     = 0;
    busy_cnt  = busy ? 1 : 0;
    overlap   = 0;
    while (!done && edges < 40) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
    end
    if (!done) edges = 99;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operand = 8'h00; amount = 8'h00; shifttype = 2'b00;
    tick();
    tick();
    check("reset_result", {24'd0, result}, 32'h00);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_done", {31'd0, done}, 32'd0);

    // SLL 0x81 by 1
    run_op(2'b00, 8'h81, 8'd1);
    check("sll_edges", edges, 2);
    check("sll_result", {24'd0, result}, 32'h02);
    check("sll_busy_cnt", busy_cnt, 2);
`ifdef SHIFT_CARRY_EN
    check("sll_carry", {31'd0, carryout}, 32'd1);
`endif
    tick();
    check("sll_done_pulse", {31'd0, done}, 32'd0);
    check("sll_hold", {24'd0, result}, 32'h02);

    // SRA 0x80 by 3
    run_op(2'b10, 8'h80, 8'd3);
    check("sra_edges", edges, 4);
    check("sra_result", {24'd0, result}, 32'hF0);
    check("sra_busy_cnt", busy_cnt, 4);
    check("sra_overlap", overlap, 0);

    // ROR 0x01 by 9 -> N=1
    run_op(2'b11, 8'h01, 8'd9);
    check("ror9_edges", edges, 2);
    check("ror9_result", {24'd0, result}, 32'h80);
`ifdef SHIFT_CARRY_EN
    check("ror9_carry", {31'd0, carryout}, 32'd1);
`endif

    // ROR 0x01 by 8 -> N=0
    run_op(2'b11, 8'h01, 8'd8);
    check("ror8_edges", edges, 1);
    check("ror8_result", {24'd0, result}, 32'h01);
    check("ror8_busy_cnt", busy_cnt, 1);
`ifdef SHIFT_CARRY_EN
    check("ror8_carry", {31'd0, carryout}, 32'd0);
`endif

    // ROR 0x01 by 3
    run_op(2'b11, 8'h01, 8'd3);
    check("ror3_result", {24'd0, result}, 32'h20);

    // SRL 0xFF by 200 -> N=8
    run_op(2'b01, 8'hFF, 8'd200);
    check("srl200_edges", edges, 9);
    check("srl200_result", {24'd0, result}, 32'h00);
`ifdef SHIFT_CARRY_EN
    check("srl200_carry", {31'd0, carryout}, 32'd1);
`endif

    // SRA of a positive value fills with zero
    run_op(2'b10, 8'h40, 8'd2);
    check("sra_pos_result", {24'd0, result}, 32'h10);
    tick();

    // SLL 0x01 by 5 with ignored START at E2, then back-to-back load
    shifttype = 2'b00; operand = 8'h01; amount = 8'd5; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    check("b2b_load", {24'd0, result}, 32'h01);
    tick();  // E1
    check("b2b_e1", {24'd0, result}, 32'h02);
    start = 1'b1; operand = 8'hAA; shifttype = 2'b11; amount = 8'd1;
    tick();  // E2, START ignored
    start = 1'b0;
    check("ignore_e2", {24'd0, result}, 32'h04);
    check("ignore_busy", {31'd0, busy}, 32'd1);
    tick(); tick(); tick();  // E3..E5
    check("sll5_e5", {24'd0, result}, 32'h20);
    check("sll5_notdone", {31'd0, done}, 32'd0);
    tick();  // E6
    check("sll5_done", {31'd0, done}, 32'd1);
    check("sll5_result", {24'd0, result}, 32'h20);
    start = 1'b1; operand = 8'h0F; shifttype = 2'b01; amount = 8'd2;
    tick();  // E7 back-to-back
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_result", {24'd0, result}, 32'h0F);
    tick(); tick(); tick();
    check("b2b_final_done", {31'd0, done}, 32'd1);
    check("b2b_final", {24'd0, result}, 32'h03);
    tick();

    // Reset mid-operation: SRL 0xF0 by 4, reset at E2
    shifttype = 2'b01; operand = 8'hF0; amount = 8'd4; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    tick();  // E1
    check("rst_mid_e1", {24'd0, result}, 32'h78);
    reset = 1'b1;
    tick();  // E2
    reset = 1'b0;
    check("rst_mid_result", {24'd0, result}, 32'h00);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    overlap = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) overlap++;
    end
    check("rst_no_done", overlap, 0);

    // Reset has priority over START
    reset = 1'b1; start = 1'b1; operand = 8'h55; amount = 8'd1; shifttype = 2'b00;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    check("rst_prio_result", {24'd0, result}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
